// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32M multiply/divide types, constants and op decoders.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_rs1_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_negate
// Brief    : Conditional two's-complement of an N-bit value.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] value,
  input  logic         negate,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  assign result = negate ? (~value + C_ONE) : value;

endmodule
`default_nettype wire

// File: rtl/muldiv_execute.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_execute
// Brief    : Multi-cycle RV32M multiply/divide unit for the execute stage.
//            Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_execute
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] rs1_data_E,
  input  logic [XLEN-1:0] rs2_data_E,
  input  logic [4:0]      rd_E,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int                  C_CNT_W   = $clog2(XLEN);
  localparam logic [C_CNT_W-1:0]  C_LAST    = C_CNT_W'(XLEN - 1);
  localparam logic [C_CNT_W-1:0]  C_CNT_ONE = C_CNT_W'(1);
  localparam logic [XLEN-1:0]     C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state;
  muldiv_op_e        r_op;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [C_CNT_W-1:0] r_count;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  muldiv_op_e        w_op;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_launch;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod_raw;
  logic [2*XLEN-1:0] w_prod;
  logic              w_prod_neg;
  muldiv_op_e        w_mul_op;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_div_rem_sel;
  logic [XLEN-1:0]   w_div_raw;
  logic              w_div_neg;
  logic [XLEN-1:0]   w_div_res;

  assign w_op = muldiv_op_e'(op_E);
  assign w_sa = op_rs1_signed(w_op) & rs1_data_E[XLEN-1];
  assign w_sb = op_rs2_signed(w_op) & rs2_data_E[XLEN-1];

  muldiv_negate #(.N(XLEN)) u_mag_a (.value(rs1_data_E), .negate(w_sa), .result(w_mag_a));
  muldiv_negate #(.N(XLEN)) u_mag_b (.value(rs2_data_E), .negate(w_sb), .result(w_mag_b));

  assign w_launch  = (r_state == ST_IDLE) & start_E & ~flush;
  assign stall_req = ~reset & (w_launch | (r_state == ST_CALC));

  // Architecturally defined divide results that bypass iteration.
  assign w_div_zero = op_is_div(w_op) && (rs2_data_E == '0);
  assign w_div_ovf  = op_is_div(w_op) && op_rs1_signed(w_op) &&
                      (rs1_data_E == C_MIN_NEG) && (rs2_data_E == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = op_is_rem(w_op) ? rs1_data_E : '1;
    end else begin
      w_special_res = op_is_rem(w_op) ? '0 : rs1_data_E;
    end
  end

  // r_acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_acc_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    if (op_is_div(r_op)) begin
      if (!w_div_diff[XLEN]) begin
        w_acc_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign w_prod_raw = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_prod_neg = w_sa ^ w_sb;
  assign w_mul_op   = w_op;
`else
  assign w_prod_raw = w_acc_next;
  assign w_prod_neg = r_neg_res;
  assign w_mul_op   = r_op;
`endif

  muldiv_negate #(.N(2*XLEN)) u_prod_fix (.value(w_prod_raw), .negate(w_prod_neg), .result(w_prod));

  assign w_mul_res = (w_mul_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Remainder takes the dividend's sign; quotient takes the xor of both signs.
  assign w_div_rem_sel = op_is_rem(r_op);
  assign w_div_raw     = w_div_rem_sel ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign w_div_neg     = w_div_rem_sel ? r_neg_rem : r_neg_res;

  muldiv_negate #(.N(XLEN)) u_div_fix (.value(w_div_raw), .negate(w_div_neg), .result(w_div_res));

  // Sign correction lands in the result register on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_rd      <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_E) begin
            r_op      <= w_op;
            r_rd      <= rd_E;
            r_opb     <= w_mag_b;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_acc     <= {{XLEN{1'b0}}, w_mag_a};
            r_count   <= C_LAST;
            if (w_special) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= rd_E;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op_is_div(w_op)) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_mul_res;
              r_rd_out <= rd_E;
            end
`endif
            else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          if (r_count == '0) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= op_is_div(r_op) ? w_div_res : w_mul_res;
            r_rd_out <= r_rd;
          end else begin
            r_count <= r_count - C_CNT_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_execute
// Brief    : Self-checking bench for muldiv_execute (vector table, corner
//            sequences and random ops against an arithmetic reference).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_execute;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        start_E = 1'b0;
  logic [2:0]  op_E = 3'd0;
  logic [31:0] rs1_data_E = '0;
  logic [31:0] rs2_data_E = '0;
  logic [4:0]  rd_E = '0;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_execute #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start_E(start_E), .op_E(op_E),
    .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .rd_E(rd_E),
    .stall_req(stall_req), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions using 64-bit math.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; return sp[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return DIV_LAT;
    end
    return MUL_LAT;
  endfunction

  // Holds start_E like a stalled pipeline register until the done strobe appears.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output int lat, output int stalls, output logic stall_at_done);
    @(posedge clk); #1;
    start_E = 1'b1; op_E = op; rs1_data_E = a; rs2_data_E = b; rd_E = rd;
    lat = -1; stalls = 0; res = '0; rdo = '0; stall_at_done = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc; res = result; rdo = rd_out; stall_at_done = stall_req;
        break;
      end
      if (stall_req) stalls++;
    end
    start_E = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat, stalls;
    logic        sad;
    do_op(op, a, b, rd, res, rdo, lat, stalls, sad);
    check({tag, " result"}, res, exp);
    check({tag, " rd_out"}, {27'd0, rdo}, {27'd0, rd});
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, " stall in done"}, {31'd0, sad}, 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    int   nd, nd2;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, DIV_LAT};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, DIV_LAT};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        DIV_LAT};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         DIV_LAT};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1};
    vecs[12] = '{3'd4, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd0, 32'd12,        32'd12,        5'd16, 32'd144,       MUL_LAT};
    vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, MUL_LAT};
    vecs[15] = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd31, 32'h0000_0001, DIV_LAT};

    // Reset state, including stall_req suppressed while reset is high.
    start_E = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall during reset", {31'd0, stall_req}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    start_E = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                    vecs[i].exp, vecs[i].lat);
    end

    // Flush of a DIV in its tenth cycle: no done, stall released, then a clean MUL.
    @(posedge clk); #1;
    start_E = 1'b1; op_E = 3'd4; rs1_data_E = 32'd1000; rs2_data_E = 32'd3; rd_E = 5'd20;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) nd++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start_E = 1'b0;
    @(negedge clk);
    check("flush stall_req dropped", {31'd0, stall_req}, 32'd0);
    count_done(40, nd2);
    check("flush no done", 32'(nd + nd2), 32'd0);
    run_and_check("post-flush MUL", 3'd0, 32'd6, 32'hFFFF_FFF9, 5'd21, 32'hFFFF_FFD6, MUL_LAT);

    // Reset in the fifth cycle of a DIV: same outcome, outputs cleared.
    @(posedge clk); #1;
    start_E = 1'b1; op_E = 3'd5; rs1_data_E = 32'd999; rs2_data_E = 32'd4; rd_E = 5'd22;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; start_E = 1'b0;
    @(negedge clk);
    check("reset mid-op stall_req", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_done(40, nd);
    check("reset mid-op no done", 32'(nd), 32'd0);
    check("reset mid-op result", result, 32'd0);
    check("reset mid-op rd_out", {27'd0, rd_out}, 32'd0);

    // start_E and flush together never launch.
    @(posedge clk); #1;
    start_E = 1'b1; flush = 1'b1; op_E = 3'd5; rs1_data_E = 32'd50; rs2_data_E = 32'd5; rd_E = 5'd23;
    @(negedge clk);
    check("start+flush stall_req", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    start_E = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start+flush idle after", {31'd0, stall_req}, 32'd0);
    count_done(40, nd);
    check("start+flush no done", 32'(nd), 32'd0);

    // Random operations against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 100));
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_and_check($sformatf("rand%0d op%0d %h %h", i, op, a, b), op, a, b,
                    5'($urandom_range(0, 31)), ref_result(op, a, b), ref_latency(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
